// File: rtl/execute_stage_reg.sv
// Y86 execute stage: ALU, condition-code register, branch/cmov condition
// evaluation, combinational forwarding outputs and the E->M pipeline register.
module execute_stage_reg #(
  parameter int         DATA_W   = 64,
  parameter int         EXT_OPS  = 0,
  parameter logic [2:0] CC_RESET = 3'b100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        E_stat,
  input  logic [3:0]        E_icode,
  input  logic [3:0]        E_ifun,
  input  logic [DATA_W-1:0] E_valC,
  input  logic [DATA_W-1:0] E_valA,
  input  logic [DATA_W-1:0] E_valB,
  input  logic [3:0]        E_dstE,
  input  logic [3:0]        E_dstM,
  input  logic [2:0]        m_stat,
  input  logic [2:0]        W_stat,
  input  logic              M_stall,
  input  logic              M_bubble,
  output logic [DATA_W-1:0] e_valE,
  output logic [3:0]        e_dstE,
  output logic              e_cnd,
  output logic [2:0]        cc,
  output logic [2:0]        M_stat,
  output logic [3:0]        M_icode,
  output logic              M_cnd,
  output logic [DATA_W-1:0] M_valE,
  output logic [DATA_W-1:0] M_valA,
  output logic [3:0]        M_dstE,
  output logic [3:0]        M_dstM
);

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOV   = 4'h2;
  localparam logic [3:0] I_IRMOV  = 4'h3;
  localparam logic [3:0] I_RMMOV  = 4'h4;
  localparam logic [3:0] I_MRMOV  = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSH   = 4'hA;
  localparam logic [3:0] I_POP    = 4'hB;

  // ALU functions (match OPq ifun encoding)
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_XOR  = 4'h3;
  localparam logic [3:0] ALU_SHL  = 4'h4;
  localparam logic [3:0] ALU_SAR  = 4'h5;

  localparam logic [2:0] S_AOK    = 3'd1;
  localparam logic [2:0] S_INS    = 3'd4;
  localparam logic [3:0] REG_NONE = 4'hF;
  localparam int         MSB      = DATA_W - 1;

  logic [DATA_W-1:0] alu_a, alu_b, alu_res;
  logic [3:0]        alu_fun;
  logic              alu_en;
  logic              op_ok;
  logic              alu_of;
  logic [5:0]        sh_amt;
  logic              sh_sat;
  logic              set_cc;
  logic [2:0]        e_stat;
  logic              cc_zf, cc_sf, cc_of;

  logic [2:0]        cc_d, cc_q;
  logic [2:0]        M_stat_d, M_stat_q;
  logic [3:0]        M_icode_d, M_icode_q;
  logic              M_cnd_d, M_cnd_q;
  logic [DATA_W-1:0] M_valE_d, M_valE_q;
  logic [DATA_W-1:0] M_valA_d, M_valA_q;
  logic [3:0]        M_dstE_d, M_dstE_q;
  logic [3:0]        M_dstM_d, M_dstM_q;

  // Operand and function selection per icode
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (which would infer a latch).
    alu_a   = '0;
    alu_b   = E_valB;
    alu_fun = ALU_ADD;
    alu_en  = 1'b1;
    case (E_icode)
      I_CMOV:                  begin alu_a = E_valA; alu_b = '0; end
      I_OPQ:                   begin alu_a = E_valA; alu_fun = E_ifun; end
      I_IRMOV:                 begin alu_a = E_valC; alu_b = '0; end
      I_RMMOV, I_MRMOV:        alu_a = E_valC;
      I_CALL, I_PUSH:          begin alu_a = DATA_W'(8); alu_fun = ALU_SUB; end
      I_RET, I_POP:            alu_a = DATA_W'(8);
      default:                 alu_en = 1'b0;
    endcase
  end

  // OPq ifun legality; shifts exist only when the extension is enabled
  always_comb begin
    op_ok = 1'b1;
    if (E_icode == I_OPQ) begin
      if (EXT_OPS != 0) op_ok = (E_ifun <= ALU_SAR);
      else              op_ok = (E_ifun <= ALU_XOR);
    end
  end

  // ALU datapath and overflow flag
  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    sh_amt  = alu_a[5:0];
    sh_sat  = (int'(sh_amt) >= DATA_W);
    case (alu_fun)
      ALU_ADD: begin
        alu_res = alu_b + alu_a;
        alu_of  = (alu_a[MSB] == alu_b[MSB]) && (alu_res[MSB] != alu_a[MSB]);
      end
      ALU_SUB: begin
        alu_res = alu_b - alu_a;
        alu_of  = (alu_a[MSB] != alu_b[MSB]) && (alu_res[MSB] != alu_b[MSB]);
      end
      ALU_AND: alu_res = alu_b & alu_a;
      ALU_XOR: alu_res = alu_b ^ alu_a;
      ALU_SHL: alu_res = sh_sat ? '0 : (alu_b << sh_amt);
      ALU_SAR: alu_res = sh_sat ? {DATA_W{alu_b[MSB]}}
                                : $unsigned($signed(alu_b) >>> sh_amt);
      default: alu_res = '0;
    endcase
  end

  // Forwarded result, status and CC write enable
  always_comb begin
    e_valE = (alu_en && op_ok) ? alu_res : '0;
    e_stat = op_ok ? E_stat : S_INS;
    set_cc = (E_icode == I_OPQ) && op_ok && (E_stat == S_AOK) &&
             (m_stat == S_AOK) && (W_stat == S_AOK) && !M_stall;
    cc_d   = set_cc ? {(alu_res == '0), alu_res[MSB], alu_of} : cc_q;
  end

  // Condition evaluation against the registered flags
  always_comb begin
    {cc_zf, cc_sf, cc_of} = cc_q;
    e_cnd = 1'b0;
    if (E_icode == I_CMOV || E_icode == I_JXX) begin
      case (E_ifun)
        4'd0:    e_cnd = 1'b1;
        4'd1:    e_cnd = (cc_sf ^ cc_of) | cc_zf;
        4'd2:    e_cnd = cc_sf ^ cc_of;
        4'd3:    e_cnd = cc_zf;
        4'd4:    e_cnd = ~cc_zf;
        4'd5:    e_cnd = ~(cc_sf ^ cc_of);
        4'd6:    e_cnd = ~(cc_sf ^ cc_of) & ~cc_zf;
        default: e_cnd = 1'b0;
      endcase
    end
    e_dstE = (E_icode == I_CMOV && !e_cnd) ? REG_NONE : E_dstE;
  end

  // Next M register contents: bubble beats stall beats normal load
  always_comb begin
    M_stat_d  = M_stat_q;
    M_icode_d = M_icode_q;
    M_cnd_d   = M_cnd_q;
    M_valE_d  = M_valE_q;
    M_valA_d  = M_valA_q;
    M_dstE_d  = M_dstE_q;
    M_dstM_d  = M_dstM_q;
    if (M_bubble) begin
      M_stat_d  = S_AOK;
      M_icode_d = I_NOP;
      M_cnd_d   = 1'b0;
      M_valE_d  = '0;
      M_valA_d  = '0;
      M_dstE_d  = REG_NONE;
      M_dstM_d  = REG_NONE;
    end else if (!M_stall) begin
      M_stat_d  = e_stat;
      M_icode_d = E_icode;
      M_cnd_d   = e_cnd;
      M_valE_d  = e_valE;
      M_valA_d  = E_valA;
      M_dstE_d  = e_dstE;
      M_dstM_d  = E_dstM;
    end
  end

  // State registers: CC and M stage, reset to CC_RESET and a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) begin
      cc_q      <= CC_RESET;
      M_stat_q  <= S_AOK;
      M_icode_q <= I_NOP;
      M_cnd_q   <= 1'b0;
      M_valE_q  <= '0;
      M_valA_q  <= '0;
      M_dstE_q  <= REG_NONE;
      M_dstM_q  <= REG_NONE;
    end else begin
      cc_q      <= cc_d;
      M_stat_q  <= M_stat_d;
      M_icode_q <= M_icode_d;
      M_cnd_q   <= M_cnd_d;
      M_valE_q  <= M_valE_d;
      M_valA_q  <= M_valA_d;
      M_dstE_q  <= M_dstE_d;
      M_dstM_q  <= M_dstM_d;
    end
  end

  assign cc      = cc_q;
  assign M_stat  = M_stat_q;
  assign M_icode = M_icode_q;
  assign M_cnd   = M_cnd_q;
  assign M_valE  = M_valE_q;
  assign M_valA  = M_valA_q;
  assign M_dstE  = M_dstE_q;
  assign M_dstM  = M_dstM_q;

  // Halt and nop carry no operands; named here so the icode table reads complete.
  localparam logic [3:0] I_UNUSED_HALT = I_HALT;

endmodule

// File: tb/tb_execute_stage_reg.sv
// Directed bench for execute_stage_reg: a vector table for ALU, flags and
// conditions, plus hand sequences for CC gating, stall/bubble, extension
// ops, shift saturation and asynchronous reset.
module tb_execute_stage_reg;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

  logic        clk, rst_n;
  logic [2:0]  E_stat, m_stat, W_stat;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM;
  logic [63:0] E_valC, E_valA, E_valB;
  logic        M_stall, M_bubble;

  // Default instance (EXT_OPS=0)
  logic [63:0] e_valE, M_valE, M_valA;
  logic [3:0]  e_dstE, M_icode, M_dstE, M_dstM;
  logic        e_cnd, M_cnd;
  logic [2:0]  cc, M_stat;
  // Extended-ops instance
  logic [63:0] e_valE_x, M_valE_x, M_valA_x;
  logic [3:0]  e_dstE_x, M_icode_x, M_dstE_x, M_dstM_x;
  logic        e_cnd_x, M_cnd_x;
  logic [2:0]  cc_x, M_stat_x;
  // Narrow extended instance (DATA_W=16)
  logic [15:0] e_valE_n, M_valE_n, M_valA_n;
  logic [3:0]  e_dstE_n, M_icode_n, M_dstE_n, M_dstM_n;
  logic        e_cnd_n, M_cnd_n;
  logic [2:0]  cc_n, M_stat_n;

  int n_checks = 0;
  int n_errors = 0;

  execute_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .m_stat(m_stat), .W_stat(W_stat), .M_stall(M_stall), .M_bubble(M_bubble),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_cnd(e_cnd), .cc(cc),
    .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd), .M_valE(M_valE),
    .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM));

  execute_stage_reg #(.EXT_OPS(1)) dut_x (
    .clk(clk), .rst_n(rst_n), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .m_stat(m_stat), .W_stat(W_stat), .M_stall(M_stall), .M_bubble(M_bubble),
    .e_valE(e_valE_x), .e_dstE(e_dstE_x), .e_cnd(e_cnd_x), .cc(cc_x),
    .M_stat(M_stat_x), .M_icode(M_icode_x), .M_cnd(M_cnd_x), .M_valE(M_valE_x),
    .M_valA(M_valA_x), .M_dstE(M_dstE_x), .M_dstM(M_dstM_x));

  execute_stage_reg #(.DATA_W(16), .EXT_OPS(1)) dut_n (
    .clk(clk), .rst_n(rst_n), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC[15:0]), .E_valA(E_valA[15:0]), .E_valB(E_valB[15:0]),
    .E_dstE(E_dstE), .E_dstM(E_dstM),
    .m_stat(m_stat), .W_stat(W_stat), .M_stall(M_stall), .M_bubble(M_bubble),
    .e_valE(e_valE_n), .e_dstE(e_dstE_n), .e_cnd(e_cnd_n), .cc(cc_n),
    .M_stat(M_stat_n), .M_icode(M_icode_n), .M_cnd(M_cnd_n), .M_valE(M_valE_n),
    .M_valA(M_valA_n), .M_dstE(M_dstE_n), .M_dstM(M_dstM_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] val_a;
    logic [63:0] val_b;
    logic [63:0] val_c;
    logic [3:0]  dst_e;
    logic [63:0] exp_vale;
    logic        exp_cnd;
    logic [3:0]  exp_dste;
    logic [2:0]  exp_cc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] c, input logic [3:0] dst_e);
    E_icode = icode; E_ifun = ifun; E_valA = a; E_valB = b; E_valC = c; E_dstE = dst_e;
  endtask

  task automatic push(input logic [3:0] icode, input logic [3:0] ifun,
                      input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                      input logic [3:0] dst_e, input logic [63:0] vale,
                      input logic cnd, input logic [3:0] dste, input logic [2:0] ccv);
    vec_t v;
    v.icode = icode; v.ifun = ifun; v.val_a = a; v.val_b = b; v.val_c = c;
    v.dst_e = dst_e; v.exp_vale = vale; v.exp_cnd = cnd; v.exp_dste = dste; v.exp_cc = ccv;
    vecs.push_back(v);
  endtask

  initial begin
    //    icode ifun valA     valB     valC     dstE | valE                  cnd dstE  cc
    push(4'h6, 4'd0, 64'd1,   ONES,    64'd0,   4'd2, 64'd0,                 0, 4'd2, 3'b100);
    push(4'h6, 4'd0, MAXP,    MAXP,    64'd0,   4'd2, 64'hFFFF_FFFF_FFFF_FFFE, 0, 4'd2, 3'b011);
    push(4'h6, 4'd1, 64'd1,   MINN,    64'd0,   4'd2, MAXP,                  0, 4'd2, 3'b001);
    push(4'h7, 4'd2, 64'd0,   64'd0,   64'h400, 4'hF, 64'd0,                 1, 4'hF, 3'b001);
    push(4'h7, 4'd1, 64'd0,   64'd0,   64'h400, 4'hF, 64'd0,                 1, 4'hF, 3'b001);
    push(4'h7, 4'd6, 64'd0,   64'd0,   64'h400, 4'hF, 64'd0,                 0, 4'hF, 3'b001);
    push(4'h2, 4'd4, 64'h1234, 64'h5555, 64'd0, 4'd3, 64'h1234,              1, 4'd3, 3'b001);
    push(4'h6, 4'd2, 64'hF0F0, 64'h0FF0, 64'd0, 4'd1, 64'h00F0,              0, 4'd1, 3'b000);
    push(4'h2, 4'd3, 64'd5,   64'd0,   64'd0,   4'd3, 64'd5,                 0, 4'hF, 3'b000);
    push(4'h6, 4'd3, 64'hAAAA, 64'hAAAA, 64'd0, 4'd1, 64'd0,                 0, 4'd1, 3'b100);
    push(4'h2, 4'd4, 64'd7,   64'd0,   64'd0,   4'd3, 64'd7,                 0, 4'hF, 3'b100);
    push(4'h2, 4'd3, 64'd7,   64'd0,   64'd0,   4'd3, 64'd7,                 1, 4'd3, 3'b100);
    push(4'h3, 4'd0, 64'd0,   64'h999, 64'h100, 4'd4, 64'h100,               0, 4'd4, 3'b100);
    push(4'h4, 4'd0, 64'hAB,  64'h1000, 64'h10, 4'hF, 64'h1010,              0, 4'hF, 3'b100);
    push(4'h5, 4'd0, 64'd0,   64'h20,  ONES - 64'd7, 4'hF, 64'h18,           0, 4'hF, 3'b100);
    push(4'h8, 4'd0, 64'd0,   64'h200, 64'd0,   4'd4, 64'h1F8,               0, 4'd4, 3'b100);
    push(4'hA, 4'd0, 64'h55,  64'h200, 64'd0,   4'd4, 64'h1F8,               0, 4'd4, 3'b100);
    push(4'h9, 4'd0, 64'd0,   64'h1F8, 64'd0,   4'd4, 64'h200,               0, 4'd4, 3'b100);
    push(4'hB, 4'd0, 64'd0,   64'h1F8, 64'd0,   4'd4, 64'h200,               0, 4'd4, 3'b100);
    push(4'h0, 4'd0, 64'h77,  64'h88,  64'h99,  4'hF, 64'd0,                 0, 4'hF, 3'b100);
    push(4'h1, 4'd0, 64'h77,  64'h88,  64'h99,  4'hF, 64'd0,                 0, 4'hF, 3'b100);
    push(4'h6, 4'd1, 64'd5,   64'd3,   64'd0,   4'd2, 64'hFFFF_FFFF_FFFF_FFFE, 0, 4'd2, 3'b010);
    push(4'h7, 4'd2, 64'd0,   64'd0,   64'h400, 4'hF, 64'd0,                 1, 4'hF, 3'b010);
    push(4'h7, 4'd5, 64'd0,   64'd0,   64'h400, 4'hF, 64'd0,                 0, 4'hF, 3'b010);
    push(4'h7, 4'd0, 64'd0,   64'd0,   64'h400, 4'hF, 64'd0,                 1, 4'hF, 3'b010);
    push(4'h7, 4'd7, 64'd0,   64'd0,   64'h400, 4'hF, 64'd0,                 0, 4'hF, 3'b010);
    push(4'h2, 4'd2, 64'h42,  64'd0,   64'd0,   4'd3, 64'h42,                1, 4'd3, 3'b010);
    push(4'h2, 4'd0, 64'h43,  64'd0,   64'd0,   4'd3, 64'h43,                1, 4'd3, 3'b010);
    push(4'h6, 4'd0, MINN,    MINN,    64'd0,   4'd2, 64'd0,                 0, 4'd2, 3'b101);
    push(4'h7, 4'd1, 64'd0,   64'd0,   64'h400, 4'hF, 64'd0,                 1, 4'hF, 3'b101);

    rst_n = 1'b0;
    E_stat = 3'd1; m_stat = 3'd1; W_stat = 3'd1;
    M_stall = 1'b0; M_bubble = 1'b0; E_dstM = 4'hA;
    drive(4'h1, 4'd0, 64'd0, 64'd0, 64'd0, 4'hF);

    // Reset state
    #12;
    check("rst cc", 64'(cc), 64'(3'b100));
    check("rst M_stat", 64'(M_stat), 64'd1);
    check("rst M_icode", 64'(M_icode), 64'd1);
    check("rst M_cnd", 64'(M_cnd), 64'd0);
    check("rst M_valE", M_valE, 64'd0);
    check("rst M_valA", M_valA, 64'd0);
    check("rst M_dstE", 64'(M_dstE), 64'hF);
    check("rst M_dstM", 64'(M_dstM), 64'hF);
    check("rst x cc", 64'(cc_x), 64'(3'b100));
    check("rst x M_icode", 64'(M_icode_x), 64'd1);
    check("rst x M_dstE", 64'(M_dstE_x), 64'hF);
    check("rst n cc", 64'(cc_n), 64'(3'b100));
    check("rst n M_stat", 64'(M_stat_n), 64'd1);
    check("rst n M_icode", 64'(M_icode_n), 64'd1);
    check("rst n M_cnd", 64'(M_cnd_n), 64'd0);
    check("rst n M_valE", 64'(M_valE_n), 64'd0);
    check("rst n M_valA", 64'(M_valA_n), 64'd0);
    check("rst n M_dstE", 64'(M_dstE_n), 64'hF);
    check("rst n M_dstM", 64'(M_dstM_n), 64'hF);
    check("nop n e_valE", 64'(e_valE_n), 64'd0);
    check("nop n e_cnd", 64'(e_cnd_n), 64'd0);
    check("nop n e_dstE", 64'(e_dstE_n), 64'hF);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table: comb outputs before the edge, M stage and cc after it
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].icode, vecs[i].ifun, vecs[i].val_a, vecs[i].val_b, vecs[i].val_c, vecs[i].dst_e);
      #1;
      check($sformatf("v%0d e_valE", i), e_valE, vecs[i].exp_vale);
      check($sformatf("v%0d e_cnd", i), 64'(e_cnd), 64'(vecs[i].exp_cnd));
      check($sformatf("v%0d e_dstE", i), 64'(e_dstE), 64'(vecs[i].exp_dste));
      check($sformatf("v%0d x e_valE", i), e_valE_x, vecs[i].exp_vale);
      check($sformatf("v%0d x e_cnd", i), 64'(e_cnd_x), 64'(vecs[i].exp_cnd));
      check($sformatf("v%0d x e_dstE", i), 64'(e_dstE_x), 64'(vecs[i].exp_dste));
      @(posedge clk); #1;
      check($sformatf("v%0d cc", i), 64'(cc), 64'(vecs[i].exp_cc));
      check($sformatf("v%0d M_valE", i), M_valE, vecs[i].exp_vale);
      check($sformatf("v%0d M_cnd", i), 64'(M_cnd), 64'(vecs[i].exp_cnd));
      check($sformatf("v%0d M_dstE", i), 64'(M_dstE), 64'(vecs[i].exp_dste));
      check($sformatf("v%0d M_icode", i), 64'(M_icode), 64'(vecs[i].icode));
      check($sformatf("v%0d M_valA", i), M_valA, vecs[i].val_a);
      check($sformatf("v%0d M_stat", i), 64'(M_stat), 64'd1);
      check($sformatf("v%0d M_dstM", i), 64'(M_dstM), 64'hA);
    end

    // CC write suppressed by a non-AOK stat downstream or in E (cc is 101 here)
    @(negedge clk);
    drive(4'h6, 4'd0, 64'd1, 64'd1, 64'd0, 4'd5);
    m_stat = 3'd3;
    @(posedge clk); #1;
    check("madr cc held", 64'(cc), 64'(3'b101));
    check("madr M_valE", M_valE, 64'd2);
    @(negedge clk);
    m_stat = 3'd1; W_stat = 3'd2;
    @(posedge clk); #1;
    check("whlt cc held", 64'(cc), 64'(3'b101));
    @(negedge clk);
    W_stat = 3'd1; E_stat = 3'd2;
    @(posedge clk); #1;
    check("ehlt cc held", 64'(cc), 64'(3'b101));
    check("ehlt M_stat", 64'(M_stat), 64'd2);

    // Stall holds M and blocks the cc write
    @(negedge clk);
    E_stat = 3'd1; M_stall = 1'b1;
    drive(4'h6, 4'd3, 64'd3, 64'd5, 64'd0, 4'd6);
    #1;
    check("stall e_valE", e_valE, 64'd6);
    @(posedge clk); #1;
    check("stall cc", 64'(cc), 64'(3'b101));
    check("stall M_valE", M_valE, 64'd2);
    check("stall M_stat", 64'(M_stat), 64'd2);
    check("stall M_dstE", 64'(M_dstE), 64'd5);
    check("stall M_icode", 64'(M_icode), 64'd6);

    // Bubble wins over stall
    @(negedge clk);
    M_bubble = 1'b1;
    @(posedge clk); #1;
    check("bub M_icode", 64'(M_icode), 64'd1);
    check("bub M_stat", 64'(M_stat), 64'd1);
    check("bub M_valE", M_valE, 64'd0);
    check("bub M_valA", M_valA, 64'd0);
    check("bub M_dstE", 64'(M_dstE), 64'hF);
    check("bub M_dstM", 64'(M_dstM), 64'hF);
    check("bub M_cnd", 64'(M_cnd), 64'd0);
    check("bub cc", 64'(cc), 64'(3'b101));

    // sar -8 by 2: INS without the extension, -2 with it
    @(negedge clk);
    M_stall = 1'b0; M_bubble = 1'b0;
    drive(4'h6, 4'd5, 64'd2, ONES - 64'd7, 64'd0, 4'd2);
    #1;
    check("sar x e_valE", e_valE_x, ONES - 64'd1);
    check("sar n e_valE", 64'(e_valE_n), 64'hFFFE);
    @(posedge clk); #1;
    check("ins M_stat", 64'(M_stat), 64'd4);
    check("ins cc held", 64'(cc), 64'(3'b101));
    check("sar x M_stat", 64'(M_stat_x), 64'd1);
    check("sar x M_valE", M_valE_x, ONES - 64'd1);
    check("sar x cc", 64'(cc_x), 64'(3'b010));

    // Asynchronous reset mid-cycle, observed before any clock edge
    @(negedge clk);
    drive(4'h6, 4'd0, 64'd1, 64'd1, 64'd0, 4'd2);
    #2 rst_n = 1'b0;
    #1;
    check("arst cc", 64'(cc), 64'(3'b100));
    check("arst M_icode", 64'(M_icode), 64'd1);
    check("arst M_dstE", 64'(M_dstE), 64'hF);
    check("arst M_stat", 64'(M_stat), 64'd1);
    check("arst x cc", 64'(cc_x), 64'(3'b100));
    @(negedge clk);
    rst_n = 1'b1;

    // Shift amounts, including saturation on the 16-bit instance
    drive(4'h6, 4'd4, 64'd4, 64'd1, 64'd0, 4'd2);
    #1;
    check("shl4 x", e_valE_x, 64'd16);
    check("shl4 n", 64'(e_valE_n), 64'd16);
    drive(4'h6, 4'd4, 64'd20, 64'd1, 64'd0, 4'd2);
    #1;
    check("shl20 x", e_valE_x, 64'h10_0000);
    check("shl20 n sat", 64'(e_valE_n), 64'd0);
    drive(4'h6, 4'd5, 64'd20, 64'h8000, 64'd0, 4'd2);
    #1;
    check("sar20 x", e_valE_x, 64'd0);
    check("sar20 n sat", 64'(e_valE_n), 64'hFFFF);
    drive(4'h6, 4'd5, 64'd16, 64'h4000, 64'd0, 4'd2);
    #1;
    check("sar16 n sat", 64'(e_valE_n), 64'd0);
    drive(4'h6, 4'd4, 64'd63, 64'd1, 64'd0, 4'd2);
    #1;
    check("shl63 x", e_valE_x, MINN);

    // ifun 6 is illegal even with the extension
    @(negedge clk);
    drive(4'h6, 4'd6, 64'd1, 64'd1, 64'd0, 4'd2);
    @(posedge clk); #1;
    check("ins6 x M_stat", 64'(M_stat_x), 64'd4);
    check("ins6 M_stat", 64'(M_stat), 64'd4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
